// File: rtl/noc_flit_router_in.sv
// noc_flit_router_in
// Router-side input port terminating the NI flit link. Incoming byte flits are
// parsed into packets (header, up to MAX_DATA data flits, tail). The 2-bit
// destination is taken from the header. Accepted flits are buffered in a FIFO
// and presented, head first, to one of four router output ports. Packets whose
// header is malformed are dropped up to the next tail flit and flagged.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   flit_in       flit from the NI
//   flit_in_valid flit_in holds a flit
//   noc_ready     port can accept a flit (at least two free FIFO entries)
//   out_flit      flit at the FIFO head (0 when empty)
//   out_valid     one-hot valid toward the head entry's destination port
//   out_ready     per-port ready from the output ports
//   out_last      head entry is the tail flit of its packet
//   err_hdr       one-cycle pulse: bad header, packet dropped
//   err_tail      one-cycle pulse: no tail after MAX_DATA data flits
//   pkt_cnt       number of packets fully enqueued, wraps at 255

module noc_flit_router_in #(
    parameter int         DEPTH      = 8,
    parameter logic [5:0] HEADER_TAG = 6'b101111,
    parameter logic [7:0] TAIL_FLIT  = 8'hFF,
    parameter int         MAX_DATA   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] flit_in,
    input  logic       flit_in_valid,
    output logic       noc_ready,
    output logic [7:0] out_flit,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic       out_last,
    output logic       err_hdr,
    output logic       err_tail,
    output logic [7:0] pkt_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DCNT_W = $clog2(MAX_DATA + 1);

    typedef enum logic [1:0] {
        ST_HEAD,
        ST_DATA,
        ST_DROP
    } state_t;

    state_t              state, state_next;
    logic [DCNT_W-1:0]   dcnt, dcnt_next;
    logic [1:0]          dest, dest_next;

    // Entry layout: {dest[1:0], last, flit[7:0]}
    logic [10:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [10:0]         head;

    logic                accept, push_req, push, pop, full, empty;
    logic                push_last, pkt_done, err_hdr_next, err_tail_next;
    logic [1:0]          push_dest;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);

    // Two free entries are required because the NI registers its flit one
    // cycle after sampling ready, so one more flit may already be in flight.
    assign noc_ready = ((CNT_W'(DEPTH) - count) >= CNT_W'(2));
    assign accept    = flit_in_valid & noc_ready;

    // Packet parser: decides what (if anything) each accepted flit pushes.
    always_comb begin
        state_next    = state;
        dcnt_next     = dcnt;
        dest_next     = dest;
        push_req      = 1'b0;
        push_last     = 1'b0;
        push_dest     = dest;
        pkt_done      = 1'b0;
        err_hdr_next  = 1'b0;
        err_tail_next = 1'b0;
        if (accept) begin
            case (state)
                ST_HEAD: begin
                    if (flit_in[7:2] == HEADER_TAG) begin
                        push_req   = 1'b1;
                        push_dest  = flit_in[1:0];
                        dest_next  = flit_in[1:0];
                        dcnt_next  = '0;
                        state_next = ST_DATA;
                    end else begin
                        err_hdr_next = 1'b1;
                        state_next   = ST_DROP;
                    end
                end
                ST_DATA: begin
                    push_req = 1'b1;
                    if (dcnt == DCNT_W'(MAX_DATA)) begin
                        // Data budget exhausted: this flit closes the packet
                        // whatever its value.
                        push_last     = 1'b1;
                        pkt_done      = 1'b1;
                        err_tail_next = (flit_in != TAIL_FLIT);
                        state_next    = ST_HEAD;
                    end else if ((dcnt != '0) && (flit_in == TAIL_FLIT)) begin
                        push_last  = 1'b1;
                        pkt_done   = 1'b1;
                        state_next = ST_HEAD;
                    end else begin
                        // First flit after the header is always data, even 0xFF.
                        dcnt_next = dcnt + DCNT_W'(1);
                    end
                end
                ST_DROP: begin
                    if (flit_in == TAIL_FLIT) begin
                        state_next = ST_HEAD;
                    end
                end
                default: begin
                    state_next = ST_HEAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_HEAD;
            dcnt     <= '0;
            dest     <= 2'd0;
            err_hdr  <= 1'b0;
            err_tail <= 1'b0;
            pkt_cnt  <= 8'd0;
        end else begin
            state    <= state_next;
            dcnt     <= dcnt_next;
            dest     <= dest_next;
            err_hdr  <= err_hdr_next;
            err_tail <= err_tail_next;
            if (pkt_done && push) begin
                pkt_cnt <= pkt_cnt + 8'd1;
            end
        end
    end

    assign head = mem[rd_ptr];
    assign push = push_req & ~full;
    // Only the ready of the head entry's own port matters.
    assign pop  = ~empty & out_ready[head[10:9]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_dest, push_last, flit_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid = empty ? 4'b0000 : (4'b0001 << head[10:9]);
    assign out_flit  = empty ? 8'h00 : head[7:0];
    assign out_last  = empty ? 1'b0 : head[8];

endmodule

// File: tb/tb_noc_flit_router_in.sv
// tb_noc_flit_router_in
// Self-checking bench for noc_flit_router_in. A packet-level reference model
// turns every accepted flit into the expected FIFO entries, error pulses and
// packet count; a monitor running on the falling clock edge compares the DUT
// outputs against the scoreboard head and retires entries as they are popped.
//
// Ports: none (top-level bench).

module tb_noc_flit_router_in;

    localparam int         DEPTH      = 8;
    localparam int         MAX_DATA   = 4;
    localparam logic [5:0] HEADER_TAG = 6'b101111;
    localparam logic [7:0] TAIL_FLIT  = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] flit_in;
    logic       flit_in_valid;
    logic       noc_ready;
    logic [7:0] out_flit;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'h0;
    logic       out_last;
    logic       err_hdr;
    logic       err_tail;
    logic [7:0] pkt_cnt;

    typedef struct {
        logic [1:0] dest;
        logic       last;
        logic [7:0] flit;
    } entry_t;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     ready_mode = 1;

    int         model_mode = 0;
    int         data_seen = 0;
    logic [1:0] cur_dest = 2'd0;
    int         exp_pkt = 0;
    bit         exp_err_hdr = 1'b0;
    bit         exp_err_tail = 1'b0;

    noc_flit_router_in #(
        .DEPTH     (DEPTH),
        .HEADER_TAG(HEADER_TAG),
        .TAIL_FLIT (TAIL_FLIT),
        .MAX_DATA  (MAX_DATA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_in      (flit_in),
        .flit_in_valid(flit_in_valid),
        .noc_ready    (noc_ready),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .err_hdr      (err_hdr),
        .err_tail     (err_tail),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Packet-level reference: header starts a packet, the first data flit is
    // never a tail, a 0xFF after that ends it, and the flit after MAX_DATA
    // data flits is forced to be the tail.
    task automatic modelAccept(input logic [7:0] f);
        entry_t e;
        e.dest = cur_dest;
        e.last = 1'b0;
        e.flit = f;
        if (model_mode == 0) begin
            if (f[7:2] == HEADER_TAG) begin
                cur_dest   = f[1:0];
                e.dest     = f[1:0];
                sb.push_back(e);
                model_mode = 1;
                data_seen  = 0;
            end else begin
                exp_err_hdr = 1'b1;
                model_mode  = 2;
            end
        end else if (model_mode == 1) begin
            if (data_seen == MAX_DATA || (data_seen > 0 && f == TAIL_FLIT)) begin
                e.last = 1'b1;
                sb.push_back(e);
                exp_pkt = (exp_pkt + 1) % 256;
                if (data_seen == MAX_DATA && f != TAIL_FLIT) begin
                    exp_err_tail = 1'b1;
                end
                model_mode = 0;
            end else begin
                sb.push_back(e);
                data_seen++;
            end
        end else begin
            if (f == TAIL_FLIT) begin
                model_mode = 0;
            end
        end
    endtask

    // Present one flit and hold it until the port takes it.
    task automatic applyStimulus(input logic [7:0] f);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            #1;
            flit_in       = f;
            flit_in_valid = 1'b1;
            if (noc_ready) begin
                modelAccept(f);
                done = 1'b1;
            end
        end
        if (!done) begin
            checkOutput("accept_timeout", 0, 1);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            flit_in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 1000 && !drained; i++) begin
            @(negedge clk);
            #2;
            flit_in_valid = 1'b0;
            if (sb.size() == 0) begin
                drained = 1'b1;
            end
        end
        if (!drained) begin
            checkOutput("drain_timeout", 0, 1);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_noc_ready", int'(noc_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_flit", int'(out_flit), 0);
        checkOutput("rst_out_last", int'(out_last), 0);
        checkOutput("rst_err_hdr", int'(err_hdr), 0);
        checkOutput("rst_err_tail", int'(err_tail), 0);
        checkOutput("rst_pkt_cnt", int'(pkt_cnt), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        flit_in_valid = 1'b0;
        rst           = 1'b1;
        sb.delete();
        model_mode   = 0;
        data_seen    = 0;
        exp_pkt      = 0;
        exp_err_hdr  = 1'b0;
        exp_err_tail = 1'b0;
        #1;
        checkResetValues();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare the head of the scoreboard with the DUT, choose the
    // next out_ready, and retire the head if the DUT will pop it.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("noc_ready", int'(noc_ready), int'((DEPTH - sb.size()) >= 2));
            if (sb.size() == 0) begin
                checkOutput("empty_out_valid", int'(out_valid), 0);
                checkOutput("empty_out_flit", int'(out_flit), 0);
                checkOutput("empty_out_last", int'(out_last), 0);
            end else begin
                checkOutput("out_valid", int'(out_valid), int'(4'b0001 << sb[0].dest));
                checkOutput("out_flit", int'(out_flit), int'(sb[0].flit));
                checkOutput("out_last", int'(out_last), int'(sb[0].last));
            end
            checkOutput("err_hdr", int'(err_hdr), int'(exp_err_hdr));
            checkOutput("err_tail", int'(err_tail), int'(exp_err_tail));
            checkOutput("pkt_cnt", int'(pkt_cnt), exp_pkt);
            exp_err_hdr  = 1'b0;
            exp_err_tail = 1'b0;
            case (ready_mode)
                0:       out_ready = 4'h0;
                1:       out_ready = 4'hF;
                default: out_ready = 4'($urandom_range(0, 15));
            endcase
            if (sb.size() > 0) begin
                if (out_ready[sb[0].dest]) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    logic [7:0] stream_flits [9];
    logic [7:0] hdr;
    logic [7:0] dflit;
    int         accepted;
    int         nd;

    initial begin
        rst           = 1'b1;
        flit_in       = 8'h00;
        flit_in_valid = 1'b0;
        #1;
        checkResetValues();
        @(negedge clk);
        #1;
        rst = 1'b0;

        // T1: four data flits to port 1
        ready_mode = 1;
        applyStimulus(8'hBD); applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44); applyStimulus(8'hFF);
        // T2: data 00 to port 0
        applyStimulus(8'hBC); applyStimulus(8'h00); applyStimulus(8'hFF);
        // T3: first data flit of 0xFF is data, not tail
        applyStimulus(8'hBF); applyStimulus(8'hFF); applyStimulus(8'h55); applyStimulus(8'hFF);
        // T4: bad header dropped up to its tail
        applyStimulus(8'h7E); applyStimulus(8'h12); applyStimulus(8'hFF);
        applyStimulus(8'hBD); applyStimulus(8'h01); applyStimulus(8'hFF);
        // T5: missing tail after MAX_DATA data flits
        applyStimulus(8'hBD); applyStimulus(8'h01); applyStimulus(8'h02);
        applyStimulus(8'h03); applyStimulus(8'h04); applyStimulus(8'h99);
        waitDrain();

        // T6: back-pressure, fill until noc_ready drops
        ready_mode = 0;
        idleCycles(2);
        stream_flits = '{8'hBE, 8'h01, 8'h02, 8'hFF, 8'hBD, 8'h05, 8'h06, 8'h07, 8'h08};
        accepted = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            #1;
            if (!noc_ready) begin
                flit_in_valid = 1'b0;
                break;
            end
            flit_in       = stream_flits[k];
            flit_in_valid = 1'b1;
            modelAccept(stream_flits[k]);
            accepted++;
        end
        idleCycles(3);
        checkOutput("fill_accepted", accepted, DEPTH - 1);
        checkOutput("fill_noc_ready", int'(noc_ready), 0);
        ready_mode = 1;
        waitDrain();

        // Reset in the middle of the still-open packet with data buffered.
        ready_mode = 0;
        idleCycles(2);
        applyStimulus(8'h07);
        idleCycles(1);
        doReset();
        ready_mode = 1;
        applyStimulus(8'h22); applyStimulus(8'hFF);
        applyStimulus(8'hBC); applyStimulus(8'hAA); applyStimulus(8'hFF);
        waitDrain();

        // Randomized packets with random back-pressure.
        ready_mode = 2;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                hdr = 8'($urandom_range(0, 255));
            end else begin
                hdr = {HEADER_TAG, 2'($urandom_range(0, 3))};
            end
            applyStimulus(hdr);
            nd = int'($urandom_range(0, 6));
            for (int d = 0; d < nd; d++) begin
                if ($urandom_range(0, 9) == 0) begin
                    dflit = 8'hFF;
                end else begin
                    dflit = 8'($urandom_range(0, 254));
                end
                applyStimulus(dflit);
            end
            applyStimulus(TAIL_FLIT);
            if ($urandom_range(0, 3) == 0) begin
                idleCycles(int'($urandom_range(1, 3)));
            end
        end
        idleCycles(2);
        ready_mode = 1;
        waitDrain();
        idleCycles(2);
        checkOutput("final_pkt_cnt", int'(pkt_cnt), exp_pkt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
